id_decode_stage: RTL

Parametrised instruction-decode stage for the RV32I pipeline: accepts fetched instruction words plus PC over a valid/ready handshake, buffers them in a small queue, and presents fully decoded fields with a format-correct, sign-extended immediate from a registered output stage. It sits between fetch and register-read/execute. It replaces pure field slicing with buffering, back-pressure, flush and immediate generation.

---
 rtl/rv_decode_pkg.sv | 47 ++++
 rtl/id_decode_stage_if.sv | 36 +++
 rtl/imm_gen.sv | 28 ++
 rtl/id_decode_stage.sv | 110 +++++++++++
 4 files changed

// File: rtl/rv_decode_pkg.sv
// rv_decode_pkg: RV32I opcode constants, immediate formats and
// decode helpers shared by the decode stage and imm_gen.
package rv_decode_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_e;

    function automatic imm_fmt_e imm_fmt(input logic [6:0] opcode);
        imm_fmt_e f;
        f = IMM_NONE;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR: f = IMM_I;
            OP_STORE:                 f = IMM_S;
            OP_BRANCH:                f = IMM_B;
            OP_LUI, OP_AUIPC:         f = IMM_U;
            OP_JAL:                   f = IMM_J;
            default:                  f = IMM_NONE;
        endcase
        return f;
    endfunction

    // Every legal opcode ends in 2'b11, so membership covers the length check.
    function automatic logic opcode_legal(input logic [6:0] opcode);
        return opcode inside {OP_R, OP_IMM, OP_LOAD, OP_STORE,
                              OP_BRANCH, OP_JAL, OP_JALR, OP_LUI,
                              OP_AUIPC, OP_FENCE, OP_SYSTEM};
    endfunction

endpackage

// File: rtl/id_decode_stage_if.sv
// id_decode_stage_if: fetch-side and execute-side valid/ready channels
// of the decode stage; master is the environment, slave the stage.
interface id_decode_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [XLEN-1:0] out_imm;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_rd,
        input  out_rs1, out_rs2, out_funct3, out_funct7, out_imm,
        input  out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_rd,
        output out_rs1, out_rs2, out_funct3, out_funct7, out_imm,
        output out_illegal
    );
endinterface

// File: rtl/imm_gen.sv
// imm_gen: combinational RV32I immediate extraction, sign-extended
// from instr[31] to XLEN.
module imm_gen
    import rv_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);
    logic [31:0] raw;

    always_comb begin
        raw = '0;
        unique case (imm_fmt(instr[6:0]))
            IMM_I: raw = {{20{instr[31]}}, instr[31:20]};
            IMM_S: raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: raw = {{19{instr[31]}}, instr[31], instr[7],
                          instr[30:25], instr[11:8], 1'b0};
            IMM_U: raw = {instr[31:12], 12'b0};
            IMM_J: raw = {{11{instr[31]}}, instr[31], instr[19:12],
                          instr[20], instr[30:21], 1'b0};
            default: raw = '0;
        endcase
    end

    assign imm = XLEN'($signed(raw));
endmodule

// File: rtl/id_decode_stage.sv
// id_decode_stage: queued RV32I decode with registered output fields.
// Define DECODE_ILLEGAL_CHECK_EN to enable the out_illegal opcode check.
module id_decode_stage
    import rv_decode_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int QDEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    id_decode_stage_if.slave   bus
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);

    logic [31:0]     q_instr [QDEPTH];
    logic [XLEN-1:0] q_pc    [QDEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic            push;
    logic            pop;
    logic [31:0]     head_instr;
    logic [XLEN-1:0] head_imm;

    logic            out_valid_q;
    logic [31:0]     instr_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] imm_q;

    assign bus.in_ready = (count < CW'(QDEPTH));
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = (count != '0) && (!out_valid_q || bus.out_ready);
    assign head_instr = q_instr[rd_ptr];

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (head_instr),
        .imm   (head_imm)
    );

    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_ptr] <= bus.in_instr;
            q_pc[wr_ptr]    <= bus.in_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            instr_q     <= '0;
            pc_q        <= '0;
            imm_q       <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (pop) begin
            out_valid_q <= 1'b1;
            instr_q     <= head_instr;
            pc_q        <= q_pc[rd_ptr];
            imm_q       <= head_imm;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

`ifdef DECODE_ILLEGAL_CHECK_EN
    logic illegal_q;

    always_ff @(posedge clk) begin
        if (rst)
            illegal_q <= 1'b0;
        else if (!flush && pop)
            illegal_q <= !opcode_legal(head_instr[6:0]);
    end

    assign bus.out_illegal = illegal_q;
`else
    assign bus.out_illegal = 1'b0;
`endif

    // Fields are sliced from the held word so they stay stable under stall.
    assign bus.out_valid  = out_valid_q;
    assign bus.out_pc     = pc_q;
    assign bus.out_imm    = imm_q;
    assign bus.out_opcode = instr_q[6:0];
    assign bus.out_rd     = instr_q[11:7];
    assign bus.out_funct3 = instr_q[14:12];
    assign bus.out_rs1    = instr_q[19:15];
    assign bus.out_rs2    = instr_q[24:20];
    assign bus.out_funct7 = instr_q[31:25];
endmodule
